// File: rtl/contador_de_periodos_pkg.sv
// contador_de_periodos_pkg: shared FSM state type and period width for the period meter.
package contador_de_periodos_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, DONE} estado_t;
  localparam int PERIODO_W = 32;
endpackage

// File: rtl/detector_de_borda.sv
// detector_de_borda: rising-edge detector with optional 2-flop synchronizer (CONTADOR_DE_PERIODOS_SYNC_EN).
module detector_de_borda (
  input  logic clk,
  input  logic rst,
  input  logic sinal_in,
  output logic rise
);
  logic s, sin_prev;
`ifdef CONTADOR_DE_PERIODOS_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk)
    sync <= rst ? 2'b00 : {sync[0], sinal_in};
  assign s = sync[1];
`else
  assign s = sinal_in;
`endif
  always_ff @(posedge clk)
    sin_prev <= rst ? 1'b0 : s;
  assign rise = s & ~sin_prev;
endmodule

// File: rtl/contador_de_periodos.sv
// contador_de_periodos: measures the period between two rising edges of sinal_in in whole ms (sync option: CONTADOR_DE_PERIODOS_SYNC_EN).
module contador_de_periodos
  import contador_de_periodos_pkg::*;
#(
  parameter int CLKS_PER_MS = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sinal_in,
  output logic                 ready,
  output logic                 done,
  output logic [PERIODO_W-1:0] periodo_ms
);
  localparam int CW = CLKS_PER_MS > 1 ? $clog2(CLKS_PER_MS) : 1;
  estado_t estado, prox;
  logic rise, wrap;
  logic [CW-1:0] cyc_cnt;
  logic [PERIODO_W-1:0] ms_cnt, ms_prox;
  detector_de_borda u_det (.clk(clk), .rst(rst), .sinal_in(sinal_in), .rise(rise));
  // ms_prox already includes a wrap in the current cycle, so a rise coinciding with a wrap counts it
  assign wrap    = cyc_cnt == CW'(CLKS_PER_MS - 1);
  assign ms_prox = (wrap && ms_cnt != '1) ? ms_cnt + 1'b1 : ms_cnt;
  assign ready   = estado == IDLE;
  assign done    = estado == DONE;
  always_comb begin
    prox = estado;
    prox = estado == IDLE      ? (start ? WAIT_EDGE : IDLE) :
           estado == WAIT_EDGE ? (rise ? MEASURE : WAIT_EDGE) :
           estado == MEASURE   ? (rise ? DONE : MEASURE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      estado     <= IDLE;
      cyc_cnt    <= '0;
      ms_cnt     <= '0;
      periodo_ms <= '0;
    end else begin
      estado <= prox;
      if (estado == WAIT_EDGE && rise) begin
        cyc_cnt <= '0;
        ms_cnt  <= '0;
      end else if (estado == MEASURE) begin
        cyc_cnt <= wrap ? '0 : cyc_cnt + CW'(1);
        ms_cnt  <= ms_prox;
        if (rise) periodo_ms <= ms_prox;
      end
    end
  end
endmodule

// File: tb/tb_contador_de_periodos.sv
// tb_contador_de_periodos: directed scoreboard bench for the period meter.
module tb_contador_de_periodos;
  localparam int C = 1000;
  logic clk = 0, rst = 1, start = 0, sinal_in = 0;
  logic ready, done, prev_done = 0;
  logic [31:0] periodo_ms;
  int checks = 0, errors = 0, pushes = 0, dones = 0;
  logic [31:0] q[$];

  contador_de_periodos #(.CLKS_PER_MS(C)) dut (
    .clk(clk), .rst(rst), .start(start), .sinal_in(sinal_in),
    .ready(ready), .done(done), .periodo_ms(periodo_ms)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drives two rising edges exactly p cycles apart; called #1 after a posedge
  task automatic medir(input int p);
    int m;
    m = p / 2;
    sinal_in = 0;
    repeat (5) @(posedge clk);
    #1 sinal_in = 1;
    repeat (m) @(posedge clk);
    #1 sinal_in = 0;
    repeat (p - m) @(posedge clk);
    #1 sinal_in = 1;
    q.push_back(32'(p / C));
    pushes++;
    repeat (4) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (done) begin
      dones++;
      chk("done_width", {31'b0, prev_done}, 32'd0);
      if (q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else chk("periodo_ms", periodo_ms, q.pop_front());
    end
    prev_done = done;
  end

  initial begin
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_periodo", periodo_ms, 32'd0);
    @(posedge clk);
    #1 sinal_in = 1;
    repeat (3) @(posedge clk);
    #1 start = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("wait_not_ready", {31'b0, ready}, 32'd0);
    @(posedge clk);
    #1;
    medir(1995);
    medir(1002);
    for (int k = 1; k <= 8; k++) medir(k * 1000 + 2);
    medir(999);
    medir(1999);
    medir(2000);
    sinal_in = 0;
    repeat (5) @(posedge clk);
    #1 sinal_in = 1;
    repeat (500) @(posedge clk);
    @(negedge clk);
    chk("periodo_hold", periodo_ms, 32'd2);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("midrst_ready", {31'b0, ready}, 32'd1);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_periodo", periodo_ms, 32'd0);
    @(posedge clk);
    #1;
    medir(3000);
    start = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("done_count", 32'(dones), 32'(pushes));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/contador_de_periodos.md
# contador_de_periodos

Period meter for a single-bit input signal. After a `start` request it waits for a rising edge of `sinal_in` and counts clock cycles until the next rising edge. It then reports the elapsed time in whole milliseconds on `periodo_ms`, with a one-cycle `done` pulse. It sits between a raw digital input (sensor or pulse source) and control logic that consumes the period value.

## Interface
- `CLKS_PER_MS`, default 1000: clock cycles per millisecond. Must be ≥ 1.
- `clk` input, 1: single system clock. All logic is on its rising edge.
- `rst` input, 1: reset. Synchronous and active-high.
- `start` input, 1: measurement request, level-sampled. Accepted only while `ready`=1.
- `sinal_in` input, 1: signal to measure.
- `ready` output, 1: block is idle and can accept `start`.
- `done` output, 1: one-cycle pulse; `periodo_ms` is valid and newly updated.
- `periodo_ms` output, 32: last measured period in ms, truncated.

## Operation
- Rising-edge detect: `rise` = `sinal_in`=1 while `sin_prev`=0.
  - `sin_prev` is the registered previous sample of `sinal_in` (or of the synchronizer output, see Configuration).
  - `sin_prev` updates every cycle in every state.
- FSM states: IDLE, WAIT_EDGE, MEASURE, DONE.
  - IDLE: `ready`=1. On `start`=1, go to WAIT_EDGE.
  - WAIT_EDGE: on `rise`, clear `cyc_cnt`=0 and `ms_cnt`=0, then go to MEASURE.
  - MEASURE: each cycle, `cyc_cnt`++. When `cyc_cnt` reaches `CLKS_PER_MS`-1, wrap it to 0 and increment `ms_cnt` (`ms_cnt` saturates at 2^32-1). On `rise`, load `periodo_ms` and go to DONE.
  - DONE: `done`=1 for exactly this cycle, then go to IDLE.
- `periodo_ms` = floor(P / `CLKS_PER_MS`), where P is the number of clock cycles between the two detected rising edges.
- `periodo_ms` holds its value until the next completed measurement.
- `start` is ignored outside IDLE. There is no abort except `rst`.
- A held-high `start` re-arms the block automatically: IDLE goes straight back to WAIT_EDGE.
- A `sinal_in` level that is already high when WAIT_EDGE is entered is not an edge. Only a 0→1 transition counts.

## Timing
- Reset values: state=IDLE, `ready`=1, `done`=0, `periodo_ms`=0, counters 0, `sin_prev`=0.
- `ready` is combinational from state=IDLE. `done` is combinational from state=DONE. Both are glitch-free registered-state decodes.
- `done` asserts 1 cycle after the cycle in which the second `rise` is detected.
- `ready` asserts 2 cycles after the second `rise`: DONE, then IDLE.
- Edge-detection latency is 1 cycle relative to the `sinal_in` change. It applies equally to both edges, so it does not affect P.
- `rst` mid-measurement returns the block to IDLE on the next edge. It discards the partial count and clears `periodo_ms`.
- A `rise` in the same cycle as a `cyc_cnt` wrap: the `ms_cnt` increment from the wrap is included in the loaded value.

## Configuration
- Macro: `CONTADOR_DE_PERIODOS_SYNC_EN`.
- Defined: `sinal_in` passes through a 2-flop synchronizer (reset 0) before edge detection. Detection latency grows by 2 cycles; the measured P is unchanged.
- Undefined: `sinal_in` feeds the edge detector directly. The caller guarantees `sinal_in` is synchronous to `clk`.

## Structure
- Package `contador_de_periodos_pkg` holds:
  - the state enum `estado_t` (IDLE, WAIT_EDGE, MEASURE, DONE);
  - localparam `PERIODO_W`=32.
- Sub-module `detector_de_borda` contains the optional synchronizer, the `sin_prev` register and the `rise` output. `clk`, `rst` and `sinal_in` go in; `rise` comes out.
- The top level contains the FSM, `cyc_cnt` (width $clog2(`CLKS_PER_MS`)), `ms_cnt` and the `periodo_ms` register.

## Test plan
- Reset: hold `rst` for 1 cycle -> `ready`=1, `done`=0, `periodo_ms`=0.
- Basic period, `CLKS_PER_MS`=1000, `start`=1, edges 1002 cycles apart -> `done` pulses once, `periodo_ms`=1.
- Loop for k=1..8: edges k*1000+2 cycles apart, `start` held high throughout -> `periodo_ms`=k each time, and the block re-arms without any IDLE gap requirement.
- Truncation: edges 1999 cycles apart -> `periodo_ms`=1. Edges exactly 2000 cycles apart -> `periodo_ms`=2.
- Pre-high input: `sinal_in`=1 when `start` is accepted, then falls and rises -> the timing reference is the later 0→1 transition.
- Reset mid-MEASURE after 500 cycles -> `ready`=1, `periodo_ms`=0, no `done`. A subsequent measurement is correct.
